// File: rtl/stream2axi_pkg.sv
// Shared types and constant helpers for the stream-to-AXI burst writer.
// Contents: FSM state enum, beat-byte and full-burst-byte constant functions.
package stream2axi_pkg;

  typedef enum logic [1:0] {IDLE, AW, W, B} state_e;

  // Bytes carried by one data beat.
  function automatic int unsigned beat_bytes(input int unsigned d_width);
    return d_width / 8;
  endfunction

  // Bytes carried by a full burst of burst_len+1 beats.
  function automatic int unsigned burst_bytes(input int unsigned d_width,
                                              input int unsigned burst_len);
    return (burst_len + 1) * (d_width / 8);
  endfunction

endpackage

// File: rtl/stream2axi_fifo.sv
// First-word-fall-through FIFO buffering stream words ahead of the burst writer.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push, push_data: write request and word (ignored while full)
//   pop            : consume the head word (ignored while empty)
//   head           : current head word, valid whenever !empty
//   count          : number of buffered words (0..2**ADDR_BITS)
//   full, empty    : occupancy flags
module stream2axi_fifo #(
  parameter int unsigned DW        = 16,
  parameter int unsigned ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DW-1:0]        push_data,
  input  logic                 pop,
  output logic [DW-1:0]        head,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef logic [ADDR_BITS:0] cnt_t;

  logic [DW-1:0]        mem [DEPTH];
  logic [ADDR_BITS-1:0] wptr_q, rptr_q;
  cnt_t                 count_q;
  logic                 do_push, do_pop;

  assign full    = (count_q == cnt_t'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= push_data;
  end

endmodule

// File: rtl/stream2axi_writer.sv
// Buffers a word stream and writes it out as meta-AXI4 bursts into a wrapping address region.
// Optional feature: define STREAM2AXI_TIMEOUT_FLUSH_EN to flush automatically after TIMEOUT
// idle cycles with words buffered; otherwise only s_flush forces partial bursts.
// Ports:
//   aclk, areset            : clock, synchronous active-high reset
//   s_valid/s_ready/s_data  : input word stream
//   s_flush                 : request to write out buffered words as a partial burst
//   awvalid/awready/awaddr/awlen : write-address channel
//   wvalid/wready/wlast/wdata    : write-data channel
//   bvalid/bready           : write-response channel
//   busy                    : burst in flight or words buffered
//   burst_cnt               : number of completed bursts (wraps at 2**32)
module stream2axi_writer
  import stream2axi_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 25,
  parameter int unsigned D_WIDTH   = 16,
  parameter logic [7:0]  BURST_LEN = 8'd7,
  parameter int unsigned FIFO_AW   = 5,
  parameter int unsigned ADDR_BASE = 0,
  parameter int unsigned ADDR_SPAN = 4096,
  parameter logic [15:0] TIMEOUT   = 16'd64
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [D_WIDTH-1:0] s_data,
  input  logic               s_flush,
  output logic               awvalid,
  input  logic               awready,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [7:0]         awlen,
  output logic               wvalid,
  input  logic               wready,
  output logic               wlast,
  output logic [D_WIDTH-1:0] wdata,
  input  logic               bvalid,
  output logic               bready,
  output logic               busy,
  output logic [31:0]        burst_cnt
);

  typedef logic [A_WIDTH-1:0] addr_t;
  typedef logic [FIFO_AW:0]   cnt_t;

  localparam int unsigned BEAT_BYTES = beat_bytes(D_WIDTH);
  localparam int unsigned FULL_BYTES = burst_bytes(D_WIDTH, 32'(BURST_LEN));
  // Highest start address that still leaves room for a full burst.
  localparam addr_t       ADDR_LIMIT = addr_t'(ADDR_BASE + ADDR_SPAN - FULL_BYTES);
  localparam cnt_t        FULL_BEATS = cnt_t'(32'(BURST_LEN) + 32'd1);

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_q, beat_d;
  addr_t       cur_addr_q, cur_addr_d;
  logic [31:0] burst_cnt_q, burst_cnt_d;
  logic        flush_pending_q, flush_pending_d;

  cnt_t        fifo_count;
  logic        fifo_full, fifo_empty;
  logic        push, pop;
  logic        start;
  logic [7:0]  start_len;
  addr_t       next_addr;

  assign s_ready   = !fifo_full && !areset;
  assign push      = s_valid && s_ready;
  assign pop       = (state_q == W) && wready;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign burst_cnt = burst_cnt_q;

  stream2axi_fifo #(
    .DW        (D_WIDTH),
    .ADDR_BITS (FIFO_AW)
  ) u_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head      (wdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign start     = (state_q == IDLE) &&
                     ((fifo_count >= FULL_BEATS) || (flush_pending_q && fifo_count != '0));
  assign start_len = (fifo_count >= FULL_BEATS) ? BURST_LEN : 8'(fifo_count - 1'b1);
  assign next_addr = cur_addr_q + addr_t'((32'(len_q) + 32'd1) * BEAT_BYTES);

`ifdef STREAM2AXI_TIMEOUT_FLUSH_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        timeout_hit;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_q != IDLE || push || fifo_count == '0) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TIMEOUT) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end
    // Fire once, on the cycle the counter reaches the limit.
    timeout_hit = (idle_cnt_d == TIMEOUT) && (idle_cnt_q != TIMEOUT);
  end

  always_ff @(posedge aclk) begin
    if (areset) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`endif

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    beat_d          = beat_q;
    cur_addr_d      = cur_addr_q;
    burst_cnt_d     = burst_cnt_q;
    flush_pending_d = flush_pending_q;
    awvalid         = 1'b0;
    awaddr          = '0;
    awlen           = '0;
    wvalid          = 1'b0;
    wlast           = 1'b0;
    bready          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = start_len;
          beat_d  = '0;
          state_d = AW;
          // The burst drains everything buffered, so the flush is satisfied.
          if (32'(start_len) + 32'd1 == 32'(fifo_count)) flush_pending_d = 1'b0;
        end
      end
      AW: begin
        awvalid = 1'b1;
        awaddr  = cur_addr_q;
        awlen   = len_q;
        if (awready) state_d = W;
      end
      W: begin
        wvalid = 1'b1;
        wlast  = (beat_q == len_q);
        if (wready) begin
          beat_d = beat_q + 8'd1;
          if (wlast) state_d = B;
        end
      end
      B: begin
        bready = 1'b1;
        if (bvalid) begin
          burst_cnt_d = burst_cnt_q + 32'd1;
          cur_addr_d  = (next_addr > ADDR_LIMIT) ? addr_t'(ADDR_BASE) : next_addr;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new flush request wins over the clear so a late request is never lost.
    if (s_flush && !(state_q == IDLE && fifo_count == '0)) flush_pending_d = 1'b1;
`ifdef STREAM2AXI_TIMEOUT_FLUSH_EN
    if (timeout_hit) flush_pending_d = 1'b1;
`endif
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q         <= IDLE;
      len_q           <= '0;
      beat_q          <= '0;
      cur_addr_q      <= addr_t'(ADDR_BASE);
      burst_cnt_q     <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      beat_q          <= beat_d;
      cur_addr_q      <= cur_addr_d;
      burst_cnt_q     <= burst_cnt_d;
      flush_pending_q <= flush_pending_d;
    end
  end

endmodule

// File: tb/tb_stream2axi_writer.sv
// Directed self-checking bench for stream2axi_writer (D_WIDTH=16, 8-beat bursts, 64-byte region).
module tb_stream2axi_writer;

  logic        aclk;
  logic        areset;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_flush;
  logic        awvalid;
  logic        awready;
  logic [24:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid;
  logic        wready;
  logic        wlast;
  logic [15:0] wdata;
  logic        bvalid;
  logic        bready;
  logic        busy;
  logic [31:0] burst_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  stream2axi_writer #(
    .A_WIDTH   (25),
    .D_WIDTH   (16),
    .BURST_LEN (8'd7),
    .FIFO_AW   (5),
    .ADDR_BASE (0),
    .ADDR_SPAN (64),
    .TIMEOUT   (16'd16)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_flush   (s_flush),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .wvalid    (wvalid),
    .wready    (wready),
    .wlast     (wlast),
    .wdata     (wdata),
    .bvalid    (bvalid),
    .bready    (bready),
    .busy      (busy),
    .burst_cnt (burst_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  // Leaves s_valid high so back-to-back pushes are possible; acceptance sampled mid-cycle.
  task automatic push_word(input logic [15:0] v, output bit acc);
    s_valid = 1'b1;
    s_data  = v;
    @(negedge aclk);
    acc = s_ready;
    tick();
  endtask

  task automatic push_seq(input logic [15:0] first, input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      push_word(first + 16'(i), acc);
      check("push_accept", {31'd0, acc}, 32'd1);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_aw(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (awvalid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Acts as the AXI slave for one complete burst and checks every field on the way.
  task automatic do_burst(input logic [24:0] exp_addr, input logic [7:0] exp_len,
                          input logic [15:0] first);
    bit seen;
    wait_aw(seen);
    check("aw_seen", {31'd0, seen}, 32'd1);
    check("awaddr", 32'(awaddr), 32'(exp_addr));
    check("awlen", 32'(awlen), 32'(exp_len));
    awready = 1'b1;
    tick();
    awready = 1'b0;
    check("awvalid_drop", {31'd0, awvalid}, 32'd0);
    wready = 1'b1;
    for (int b = 0; b <= 32'(exp_len); b++) begin
      check("wvalid", {31'd0, wvalid}, 32'd1);
      check("wdata", 32'(wdata), 32'(first + 16'(b)));
      check("wlast", {31'd0, wlast}, (b == 32'(exp_len)) ? 32'd1 : 32'd0);
      tick();
    end
    wready = 1'b0;
    check("bready", {31'd0, bready}, 32'd1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check("bready_drop", {31'd0, bready}, 32'd0);
  endtask

  initial begin
    bit          seen;
    bit          aw_seen;
    bit          acc;
    int          acc_cnt;
    int          cyc;
    logic [15:0] val;

    areset  = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_flush = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_awvalid", {31'd0, awvalid}, 32'd0);
    check("rst_wvalid", {31'd0, wvalid}, 32'd0);
    check("rst_wlast", {31'd0, wlast}, 32'd0);
    check("rst_bready", {31'd0, bready}, 32'd0);
    check("rst_awaddr", 32'(awaddr), 32'd0);
    check("rst_awlen", 32'(awlen), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_burst_cnt", burst_cnt, 32'd0);
    areset = 1'b0;
    tick();
    check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

    // Full burst of 8 words
    push_seq(16'h0001, 8);
    do_burst(25'd0, 8'd7, 16'h0001);
    check("full_burst_cnt", burst_cnt, 32'd1);
    check("full_busy", {31'd0, busy}, 32'd0);

    // Partial burst forced by s_flush; next address continues at 16
    push_seq(16'h0101, 3);
    repeat (4) tick();
    check("partial_no_aw", {31'd0, awvalid}, 32'd0);
    check("partial_busy", {31'd0, busy}, 32'd1);
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    do_burst(25'd16, 8'd2, 16'h0101);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_burst_cnt", burst_cnt, 32'd2);

    // Five bursts walk the 64-byte region and wrap back to 0
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push_seq(16'h0200 + 16'(8 * k), 8);
      do_burst(25'((16 * k) % 64), 8'd7, 16'h0200 + 16'(8 * k));
    end
    check("wrap_burst_cnt", burst_cnt, 32'd5);

    // Address channel stalled: AW fields hold, FIFO fills to 32 and backpressures
    do_reset();
    acc_cnt = 0;
    aw_seen = 1'b0;
    val     = 16'h0300;
    for (int i = 0; i < 40; i++) begin
      push_word(val, acc);
      if (acc) begin
        acc_cnt++;
        val = val + 16'd1;
      end
      if (aw_seen) begin
        check("stall_awvalid", {31'd0, awvalid}, 32'd1);
        check("stall_awaddr", 32'(awaddr), 32'd0);
      end else if (awvalid) begin
        aw_seen = 1'b1;
      end
    end
    s_valid = 1'b0;
    check("stall_accepted", acc_cnt, 32'd32);
    check("stall_s_ready", {31'd0, s_ready}, 32'd0);
    check("stall_aw_seen", {31'd0, aw_seen}, 32'd1);
    check("stall_awlen", 32'(awlen), 32'd7);
    for (int k = 0; k < 4; k++) begin
      do_burst(25'(16 * k), 8'd7, 16'h0300 + 16'(8 * k));
    end
    check("stall_burst_cnt", burst_cnt, 32'd4);
    check("stall_busy", {31'd0, busy}, 32'd0);

    // Reset during beat 4 of the data phase abandons the burst
    do_reset();
    push_seq(16'h0400, 8);
    wait_aw(seen);
    check("abort_aw_seen", {31'd0, seen}, 32'd1);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    wready  = 1'b1;
    for (int b = 0; b < 4; b++) tick();
    check("abort_beat4_data", 32'(wdata), 32'h0404);
    check("abort_beat4_valid", {31'd0, wvalid}, 32'd1);
    areset = 1'b1;
    tick();
    check("abort_wvalid", {31'd0, wvalid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_burst_cnt", burst_cnt, 32'd0);
    check("abort_s_ready", {31'd0, s_ready}, 32'd0);
    wready = 1'b0;
    areset = 1'b0;
    tick();
    check("abort_post_s_ready", {31'd0, s_ready}, 32'd1);
    check("abort_post_awvalid", {31'd0, awvalid}, 32'd0);
    push_seq(16'h0500, 8);
    do_burst(25'd0, 8'd7, 16'h0500);
    check("abort_next_cnt", burst_cnt, 32'd1);

    // Idle timeout with three words buffered
    push_seq(16'h0600, 3);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (awvalid) begin
        seen = 1'b1;
        cyc  = i;
        break;
      end
    end
`ifdef STREAM2AXI_TIMEOUT_FLUSH_EN
    check("timeout_aw_seen", {31'd0, seen}, 32'd1);
    check("timeout_delay_ok", (cyc >= 15 && cyc <= 18) ? 32'd1 : 32'd0, 32'd1);
    check("timeout_awlen", 32'(awlen), 32'd2);
`else
    check("no_timeout_aw", {31'd0, seen}, 32'd0);
    check("no_timeout_busy", {31'd0, busy}, 32'd1);
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
`endif
    do_burst(25'd16, 8'd2, 16'h0600);
    check("timeout_burst_cnt", burst_cnt, 32'd2);
    check("timeout_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream2axi_writer.md
STREAM2AXI_WRITER -- requirements
Module: stream2axi_writer

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high: one clock; reset is synchronous and active-high.
REQ-002 SHALL have these parameters (name, default, meaning):
- A_WIDTH, 25: meta-AXI4 byte-address width.
- D_WIDTH, 16: data width in bits; a multiple of 8.
- BURST_LEN, 8'd7: awlen of a full burst (8 beats).
- FIFO_AW, 5: log2 of the FIFO depth; the depth SHALL be at least 2*(BURST_LEN+1).
- ADDR_BASE, 0: start of the write region.
- ADDR_SPAN, 4096: region size in bytes; a multiple of the full-burst byte count.
- TIMEOUT, 16'd64: idle cycles before an automatic flush.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- aclk, in, 1: clock.
- areset, in, 1: synchronous active-high reset.
- s_valid, in, 1: input word valid.
- s_ready, out, 1: input word accepted.
- s_data, in, D_WIDTH: input word.
- s_flush, in, 1: pulse requesting that buffered words be written.
- awvalid/awready, out/in, 1: meta-AXI4 write-address handshake.
- awaddr, out, A_WIDTH: burst start address.
- awlen, out, 8: beats minus 1.
- wvalid/wready, out/in, 1: write-data handshake.
- wlast, out, 1: final beat of the burst.
- wdata, out, D_WIDTH: write data.
- bvalid, in, 1: write response.
- bready, out, 1: response accept.
- busy, out, 1: a burst is in flight or words are buffered.
- burst_cnt, out, 32: completed bursts.

Function
REQ-004 SHALL buffer input words in a first-word-fall-through FIFO.
- s_ready = !fifo_full.
- A word is written when s_valid && s_ready.
REQ-005 SHALL run the FSM IDLE -> AW -> W -> B -> IDLE.
REQ-006 In IDLE, SHALL start a burst when count >= BURST_LEN+1, or when flush_pending && count > 0.
- On start it SHALL latch len = min(count, BURST_LEN+1) - 1 and move to AW.
REQ-007 In AW, SHALL assert awvalid with awaddr = cur_addr and awlen = len.
- awvalid and both fields SHALL stay stable until awready.
- On awready it SHALL move to W on the next cycle.
REQ-008 In W, SHALL assert wvalid with wdata = FIFO head.
- The FIFO SHALL pop on wvalid && wready.
- wlast SHALL be asserted exactly on beat len.
- After the wlast handshake it SHALL move to B.
REQ-009 bready SHALL be 1 in state B only. On bvalid the block SHALL:
- increment burst_cnt;
- set cur_addr += (len+1)*(D_WIDTH/8);
- move to IDLE.
REQ-010 SHALL wrap cur_addr to ADDR_BASE if the new address is greater than ADDR_BASE + ADDR_SPAN - (BURST_LEN+1)*(D_WIDTH/8).
REQ-011 flush_pending behaviour:
- SHALL be set by s_flush in any state.
- SHALL clear when a burst starts whose len+1 equals count at that moment.
- s_flush with an empty FIFO in IDLE SHALL be ignored and SHALL NOT set flush_pending.
REQ-012 Simultaneous push and pop SHALL leave count unchanged. Push while full SHALL be impossible because s_ready=0.
REQ-013 busy SHALL equal (state != IDLE) || (count != 0).
REQ-014 Address arithmetic SHALL be modulo 2^A_WIDTH. burst_cnt SHALL wrap at 2^32.

Reset
REQ-015 When areset is sampled high, the following SHALL hold on the next edge:
- state = IDLE and the FIFO is empty;
- cur_addr = ADDR_BASE and burst_cnt = 0;
- flush_pending = 0 and the idle counter = 0;
- awvalid = wvalid = wlast = bready = 0, and awaddr and awlen = 0;
- s_ready = 0 while areset is high, and 1 afterwards.
REQ-016 A reset mid-burst SHALL abandon the burst without completing the AXI transaction.

Configuration
REQ-017 With STREAM2AXI_TIMEOUT_FLUSH_EN defined:
- an idle counter SHALL count cycles in IDLE with count > 0 and no push;
- it SHALL reset on any push or on leaving IDLE;
- on reaching TIMEOUT it SHALL set flush_pending.
REQ-018 Without STREAM2AXI_TIMEOUT_FLUSH_EN, the idle counter SHALL be absent and only s_flush SHALL set flush_pending.

Structure
REQ-019 SHALL place these in package stream2axi_pkg:
- the FSM state enum (IDLE, AW, W, B);
- the beat-byte and full-burst-byte constant functions.
REQ-020 SHALL implement the FIFO as the sub-module stream2axi_fifo, with FWFT, a count output, and full and empty flags.

Verification (D_WIDTH=16, BURST_LEN=7, ADDR_BASE=0, ADDR_SPAN=64, FIFO_AW=5)
REQ-021 Push 0x0001..0x0008 -> one AW with awaddr=0, awlen=7; 8 beats in order; wlast on 0x0008; burst_cnt=1; next awaddr=16.
REQ-022 Push 3 words then pulse s_flush -> awlen=2; wlast on the 3rd beat; busy=0 after bvalid.
REQ-023 Push 40 words -> awaddr sequence 0, 16, 32, 48, 0; burst_cnt=5.
REQ-024 Hold awready=0 for 20 cycles while pushing -> awvalid and awaddr stable; s_ready=0 once 32 words are buffered.
REQ-025 Assert areset during beat 4 of W -> next cycle wvalid=0, busy=0, and burst_cnt keeps its reset value of 0.
REQ-026 Timeout (TIMEOUT=16):
- with the macro: 3 words then idle -> AW with awlen=2 issued 16 cycles after the last push;
- without the macro: no AW.
